// File: rtl/dsp_core_pkg.sv
// Shared DSP-core definitions: word widths, vector types and the sign-magnitude
// <-> two's-complement helpers used by both the forward and inverse C_1 stages.
package dsp_core_pkg;

  localparam int W  = 12;
  localparam int IW = W + 4;

  typedef logic [7:0][W-1:0]  sm_vec_t;
  typedef logic [7:0][IW-1:0] tc_vec_t;

  // -0 falls out as 0 because negating a zero magnitude yields zero.
  function automatic logic [IW-1:0] sm_to_tc(input logic [W-1:0] sm);
    logic [IW-1:0] mag;
    mag = {{(IW-W+1){1'b0}}, sm[W-2:0]};
    return sm[W-1] ? (~mag + IW'(1)) : mag;
  endfunction

  // Divide by 8 rounding half away from zero; sign only survives a nonzero result.
  function automatic logic [W-1:0] tc_to_sm_div8(input logic [IW-1:0] x);
    logic [IW-1:0] abs_v;
    logic [IW-1:0] rnd;
    logic [W-2:0]  mag;
    abs_v = x[IW-1] ? (~x + IW'(1)) : x;
    rnd   = (abs_v + IW'(4)) >> 3;
    // Upper bits are always zero for legal inputs; fold them in as a clamp.
    mag   = rnd[W-2:0] | {(W-1){|rnd[IW-1:W-1]}};
    return {x[IW-1] & (|mag), mag};
  endfunction

endpackage

// File: rtl/wht_bfly_stage.sv
// One registered radix-2 Walsh-Hadamard butterfly layer over 8 lanes at a given span.
// Lane lo gets a+b, lane lo+SPAN gets a-b; the valid bit rides along.
module wht_bfly_stage #(
  parameter int SPAN = 1,
  parameter int IW   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                in_valid,
  input  logic [7:0][IW-1:0]  in_data,
  output logic                out_valid,
  output logic [7:0][IW-1:0]  out_data
);

  logic               valid_d, valid_q;
  logic [7:0][IW-1:0] data_d, data_q;
  logic [7:0][IW-1:0] bfly;

  for (genvar p = 0; p < 4; p++) begin : g_pair
    localparam int LO = (p / SPAN) * 2 * SPAN + (p % SPAN);
    localparam int HI = LO + SPAN;
    assign bfly[LO] = in_data[LO] + in_data[HI];
    assign bfly[HI] = in_data[LO] - in_data[HI];
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (en) begin
      valid_d = in_valid;
      data_d  = bfly;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/c_1_inverse.sv
// 8-point inverse Walsh-Hadamard transform, natural order, 5-stage pipeline:
// input conversion, three butterfly layers, scale-by-1/8 with rounding to sign-magnitude.
// Handshake: I_VALID is sampled on every rising CLK with EN=1 and reappears as O_VALID
// exactly 5 enabled edges later; EN=0 freezes every register, there is no backpressure.
module c_1_inverse
  import dsp_core_pkg::*;
(
  input  logic         CLK,
  input  logic         RESET,
  input  logic         EN,
  input  logic         I_VALID,
  input  logic [W-1:0] I0,
  input  logic [W-1:0] I1,
  input  logic [W-1:0] I2,
  input  logic [W-1:0] I3,
  input  logic [W-1:0] I4,
  input  logic [W-1:0] I5,
  input  logic [W-1:0] I6,
  input  logic [W-1:0] I7,
  output logic         O_VALID,
  output logic [W-1:0] O0,
  output logic [W-1:0] O1,
  output logic [W-1:0] O2,
  output logic [W-1:0] O3,
  output logic [W-1:0] O4,
  output logic [W-1:0] O5,
  output logic [W-1:0] O6,
  output logic [W-1:0] O7
);

  sm_vec_t in_vec;
  logic    s0_valid_d, s0_valid_q;
  tc_vec_t s0_data_d, s0_data_q;
  logic    s1_valid, s2_valid, s3_valid;
  tc_vec_t s1_data, s2_data, s3_data;
  logic    out_valid_d, out_valid_q;
  sm_vec_t out_data_d, out_data_q;

  assign in_vec = {I7, I6, I5, I4, I3, I2, I1, I0};

  always_comb begin
    s0_valid_d = s0_valid_q;
    s0_data_d  = s0_data_q;
    if (EN) begin
      s0_valid_d = I_VALID;
      for (int k = 0; k < 8; k++) begin
        s0_data_d[k] = sm_to_tc(in_vec[k]);
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s0_valid_q <= 1'b0;
      s0_data_q  <= '0;
    end else begin
      s0_valid_q <= s0_valid_d;
      s0_data_q  <= s0_data_d;
    end
  end

  wht_bfly_stage #(.SPAN(1), .IW(IW)) u_stage1 (
    .clk       (CLK),
    .rst       (RESET),
    .en        (EN),
    .in_valid  (s0_valid_q),
    .in_data   (s0_data_q),
    .out_valid (s1_valid),
    .out_data  (s1_data)
  );

  wht_bfly_stage #(.SPAN(2), .IW(IW)) u_stage2 (
    .clk       (CLK),
    .rst       (RESET),
    .en        (EN),
    .in_valid  (s1_valid),
    .in_data   (s1_data),
    .out_valid (s2_valid),
    .out_data  (s2_data)
  );

  wht_bfly_stage #(.SPAN(4), .IW(IW)) u_stage3 (
    .clk       (CLK),
    .rst       (RESET),
    .en        (EN),
    .in_valid  (s2_valid),
    .in_data   (s2_data),
    .out_valid (s3_valid),
    .out_data  (s3_data)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (EN) begin
      out_valid_d = s3_valid;
      for (int k = 0; k < 8; k++) begin
        out_data_d[k] = tc_to_sm_div8(s3_data[k]);
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign O_VALID = out_valid_q;
  assign O0 = out_data_q[0];
  assign O1 = out_data_q[1];
  assign O2 = out_data_q[2];
  assign O3 = out_data_q[3];
  assign O4 = out_data_q[4];
  assign O5 = out_data_q[5];
  assign O6 = out_data_q[6];
  assign O7 = out_data_q[7];

endmodule
